// File: rtl/instr_mem_if.sv
// instr_mem_if: fetch, load and status signals between the program counter/loader and instr_mem.
interface instr_mem_if #(parameter int WORD_W = 8, parameter int ADDR_W = 3);
    logic [ADDR_W-1:0] Read_addr;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [WORD_W-1:0] load_data;
    logic              load_done;
    logic [WORD_W-1:0] Instruction;
    logic              instr_valid;
    logic [ADDR_W:0]   word_count;
    logic              ready;
    logic              fetch_err;
    logic              load_err;
    modport master (
        output Read_addr, load_en, load_addr, load_data, load_done,
        input  Instruction, instr_valid, word_count, ready, fetch_err, load_err
    );
    modport slave (
        input  Read_addr, load_en, load_addr, load_data, load_done,
        output Instruction, instr_valid, word_count, ready, fetch_err, load_err
    );
endinterface

// File: rtl/instr_mem.sv
// instr_mem: 2^ADDR_W-word instruction memory with EMPTY/LOADING/READY load controller.
// Define IMEM_RELOAD_EN to let load_en in READY restart loading instead of flagging load_err.
module instr_mem #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 3
) (
    input logic        clk,
    input logic        reset,
    instr_mem_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    typedef enum logic [1:0] {EMPTY, LOADING, READY} state_t;

    state_t              state_q, state_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [WORD_W-1:0]   instr_q, instr_d;
    logic                ivalid_q, ivalid_d;
    logic                ferr_q, ferr_d;
    logic                lerr_q, lerr_d;
    logic                we;
    logic [WORD_W-1:0]   mem_q [DEPTH];

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        count_d  = count_q;
        instr_d  = '0;
        ivalid_d = 1'b0;
        ferr_d   = ferr_q;
        lerr_d   = lerr_q;
        we       = 1'b0;
        case (state_q)
            EMPTY: begin
                we      = bus.load_en;
                state_d = bus.load_en ? LOADING : EMPTY;
            end
            LOADING: begin
                we      = bus.load_en;
                state_d = bus.load_done ? READY : LOADING;
            end
            default: begin
`ifdef IMEM_RELOAD_EN
                we      = bus.load_en;
                state_d = bus.load_en ? LOADING : READY;
`else
                lerr_d  = lerr_q | bus.load_en;
`endif
                if (!we) begin
                    instr_d  = valid_q[bus.Read_addr] ? mem_q[bus.Read_addr] : '0;
                    ivalid_d = valid_q[bus.Read_addr];
                    ferr_d   = ferr_q | ~valid_q[bus.Read_addr];
                end
            end
        endcase
        if (we) begin
            valid_d[bus.load_addr] = 1'b1;
            count_d = valid_q[bus.load_addr] ? count_q : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= EMPTY;
            valid_q  <= '0;
            count_q  <= '0;
            instr_q  <= '0;
            ivalid_q <= 1'b0;
            ferr_q   <= 1'b0;
            lerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            instr_q  <= instr_d;
            ivalid_q <= ivalid_d;
            ferr_q   <= ferr_d;
            lerr_q   <= lerr_d;
        end
    end

    // Array contents survive reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (we) mem_q[bus.load_addr] <= bus.load_data;
    end

    assign bus.Instruction = instr_q;
    assign bus.instr_valid = ivalid_q;
    assign bus.word_count  = count_q;
    assign bus.ready       = (state_q == READY);
    assign bus.fetch_err   = ferr_q;
`ifdef IMEM_RELOAD_EN
    assign bus.load_err    = 1'b0;
`else
    assign bus.load_err    = lerr_q;
`endif
endmodule

// File: tb/tb_instr_mem.sv
// tb_instr_mem: directed self-checking bench for instr_mem.
module tb_instr_mem;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    instr_mem_if #(.WORD_W(8), .ADDR_W(3)) bus ();
    instr_mem #(.WORD_W(8), .ADDR_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [7:0] d);
        bus.load_en = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        tick();
        bus.load_en = 1'b0;
    endtask

    task automatic done();
        bus.load_done = 1'b1;
        tick();
        bus.load_done = 1'b0;
    endtask

    task automatic fetch(input string tag, input logic [2:0] a, input logic [7:0] ei, input logic ev);
        bus.Read_addr = a;
        tick();
        chk({tag, "_instr"}, 32'(bus.Instruction), 32'(ei));
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'(ev));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        bus.Read_addr = '0;
        bus.load_en = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.load_done = 1'b0;
        tick();
        chk("rst_instr", 32'(bus.Instruction), 0);
        chk("rst_valid", 32'(bus.instr_valid), 0);
        chk("rst_count", 32'(bus.word_count), 0);
        chk("rst_ready", 32'(bus.ready), 0);
        chk("rst_ferr", 32'(bus.fetch_err), 0);
        chk("rst_lerr", 32'(bus.load_err), 0);
        reset = 1'b1;

        // full program 0x11..0x88
        for (int i = 0; i < 8; i++) load(3'(i), 8'(8'h11 * (i + 1)));
        chk("full_count", 32'(bus.word_count), 8);
        chk("full_notready", 32'(bus.ready), 0);
        chk("loading_valid", 32'(bus.instr_valid), 0);
        done();
        chk("full_ready", 32'(bus.ready), 1);
        chk("entry_instr", 32'(bus.Instruction), 0);
        fetch("sweep0", 3'd0, 8'h11, 1'b1);
        fetch("sweep1", 3'd1, 8'h22, 1'b1);
        fetch("sweep2", 3'd2, 8'h33, 1'b1);
        fetch("sweep3", 3'd3, 8'h44, 1'b1);
        fetch("sweep4", 3'd4, 8'h55, 1'b1);
        fetch("sweep5", 3'd5, 8'h66, 1'b1);
        fetch("sweep6", 3'd6, 8'h77, 1'b1);
        fetch("sweep7", 3'd7, 8'h88, 1'b1);
        fetch("wrap0", 3'd0, 8'h11, 1'b1);
        chk("full_ferr", 32'(bus.fetch_err), 0);
        chk("full_lerr", 32'(bus.load_err), 0);

        // load_en while READY
        load(3'd5, 8'h55);
`ifdef IMEM_RELOAD_EN
        chk("reload_ready", 32'(bus.ready), 0);
        chk("reload_valid", 32'(bus.instr_valid), 0);
        chk("reload_lerr", 32'(bus.load_err), 0);
        chk("reload_count", 32'(bus.word_count), 8);
        done();
        fetch("reload5", 3'd5, 8'h55, 1'b1);
`else
        chk("noreload_lerr", 32'(bus.load_err), 1);
        chk("noreload_ready", 32'(bus.ready), 1);
        chk("noreload_count", 32'(bus.word_count), 8);
        fetch("noreload5", 3'd5, 8'h66, 1'b1);
        chk("lerr_sticky", 32'(bus.load_err), 1);
`endif

        // partial program, sticky fetch error, old program gone after reset
        do_reset();
        chk("rst2_lerr", 32'(bus.load_err), 0);
        chk("rst2_count", 32'(bus.word_count), 0);
        load(3'd0, 8'hA0);
        load(3'd1, 8'hA1);
        done();
        fetch("part2", 3'd2, 8'h00, 1'b0);
        chk("part_ferr", 32'(bus.fetch_err), 1);
        fetch("part0", 3'd0, 8'hA0, 1'b1);
        chk("ferr_sticky", 32'(bus.fetch_err), 1);
        fetch("part1", 3'd1, 8'hA1, 1'b1);
        fetch("old3", 3'd3, 8'h00, 1'b0);

        // rewrite of the same address
        do_reset();
        chk("rst3_ferr", 32'(bus.fetch_err), 0);
        load(3'd3, 8'h33);
        load(3'd3, 8'h3C);
        chk("rewrite_count", 32'(bus.word_count), 1);
        done();
        fetch("rewrite3", 3'd3, 8'h3C, 1'b1);

        // asynchronous reset mid-load
        do_reset();
        for (int i = 0; i < 4; i++) load(3'(i), 8'(8'hB0 + i));
        chk("mid_count", 32'(bus.word_count), 4);
        reset = 1'b0;
        #2;
        chk("async_count", 32'(bus.word_count), 0);
        reset = 1'b1;
        tick();
        done();
        chk("ld_alone_ready", 32'(bus.ready), 0);
        chk("ld_alone_count", 32'(bus.word_count), 0);
        chk("ld_alone_valid", 32'(bus.instr_valid), 0);
        fetch("empty_fetch", 3'd0, 8'h00, 1'b0);
        chk("empty_ferr", 32'(bus.fetch_err), 0);

        // load_en and load_done on the same LOADING edge
        load(3'd0, 8'h10);
        chk("first_ready", 32'(bus.ready), 0);
        bus.load_done = 1'b1;
        load(3'd7, 8'h77);
        bus.load_done = 1'b0;
        chk("same_ready", 32'(bus.ready), 1);
        chk("same_count", 32'(bus.word_count), 2);
        fetch("same7", 3'd7, 8'h77, 1'b1);
        fetch("same0", 3'd0, 8'h10, 1'b1);
        chk("same_ferr", 32'(bus.fetch_err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_mem.md
# instr_mem

Instruction memory serving the 3-bit `Read_addr` stream produced by the program counter. Holds up to 8 instruction words loaded through a simple write port, then returns the word at the fetched address one cycle after sampling, with a per-word valid flag. A three-state controller (EMPTY, LOADING, READY) gates loading against fetching and reports protocol errors.

## Interface
- `WORD_W`, 8, instruction word width in bits
- `ADDR_W`, 3, address width; depth is 2^ADDR_W (8 words)

- `clk` input 1: single clock; all state updates on rising edge
- `reset` input 1: asynchronous, active-low; `reset`=0 clears all state immediately
- `Read_addr` input ADDR_W: fetch address from the program counter
- `load_en` input 1: write strobe; writes `load_data` to `load_addr` this edge
- `load_addr` input ADDR_W: write address
- `load_data` input WORD_W: write data
- `load_done` input 1: end-of-program pulse
- `Instruction` output WORD_W: registered fetched word
- `instr_valid` output 1: `Instruction` holds a loaded word
- `word_count` output ADDR_W+1: number of distinct addresses loaded, 0..8
- `ready` output 1: state is READY
- `fetch_err` output 1: sticky; fetch of an unloaded address in READY
- `load_err` output 1: sticky; `load_en` asserted in READY with reload disabled

## Operation
- Storage: 2^ADDR_W × WORD_W array plus one valid bit per word. Reset clears valid bits, not array contents.
- EMPTY (reset state):
  - `load_en`=1 → write the word, set its valid bit, go to LOADING.
  - `load_done` alone is ignored.
- LOADING:
  - `load_en`=1 → write the word and set its valid bit.
  - `word_count` increments only when the written word's valid bit was previously 0. A rewrite replaces the data without incrementing.
  - `load_done`=1 → go to READY. If `load_en` is also 1 that edge, the write is performed first.
- READY:
  - Each edge, sample `Read_addr`.
  - If that word is valid: `Instruction` ← word, `instr_valid` ← 1.
  - Otherwise: `Instruction` ← 0, `instr_valid` ← 0, `fetch_err` ← 1 (sticky).
  - `load_en` handling is set by Configuration.
- EMPTY and LOADING: `Instruction`=0 and `instr_valid`=0. No fetch errors are raised.
- Address wrap-around (7→0 from the PC) needs no special handling; the index is simply ADDR_W bits.
- `ready` = 1 only in READY.
- Sticky errors clear only on reset.

## Timing
- Reset values: `Instruction`=0, `instr_valid`=0, `word_count`=0, `ready`=0, `fetch_err`=0, `load_err`=0, state EMPTY, all valid bits 0.
- Fetch latency: one cycle. `Read_addr` sampled at edge N produces `Instruction`/`instr_valid` after edge N.
  - The PC updates on the falling edge, so `Read_addr` is stable at each rising edge.
- Write latency: a word written at edge N is fetchable from edge N+1. There is no same-edge bypass.
- READY entry: the first fetch is sampled on the edge after the `load_done` edge.
- Reset mid-operation (any state, including mid-load): asynchronous return to EMPTY with all valid bits cleared. The previous program is unfetchable until reloaded.

## Configuration
- `IMEM_RELOAD_EN` defined:
  - `load_en` in READY writes the word, updates `word_count`, and moves to LOADING (fetches stop, `instr_valid`=0).
  - `load_err` is tied to 0.
- Not defined:
  - `load_en` in READY is ignored (no write, no state change) and sets `load_err`.
  - Fetching continues uninterrupted.

## Test plan
- Reset, load 0x11..0x88 at addresses 0..7, pulse `load_done`, sweep `Read_addr` 0..7 → `Instruction` 0x11..0x88 one cycle after each sample, `instr_valid`=1, `word_count`=8, `ready`=1, no errors.
- Load only addresses 0,1 (0xA0, 0xA1), `load_done`, fetch address 2 → `Instruction`=0, `instr_valid`=0, `fetch_err`=1; it stays 1 after later valid fetches of address 0 (0xA0).
- Write address 3 twice (0x33, then 0x3C) → `word_count`=1; fetching address 3 in READY returns 0x3C.
- Assert `reset`=0 mid-load after 4 words, release, pulse `load_done` alone → state stays EMPTY, `word_count`=0, `ready`=0, `instr_valid`=0.
- In READY, `load_en` to address 5 with 0x55:
  - Without `IMEM_RELOAD_EN`: `load_err`=1, old word still returned.
  - With `IMEM_RELOAD_EN`: `ready`=0; after `load_done`, address 5 returns 0x55.
- `load_en` and `load_done` on the same edge in LOADING (address 7, 0x77) → READY next cycle; fetching address 7 returns 0x77, `instr_valid`=1.
